// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the timeout timer block.
//   TW_DEFAULT    : default width of the timeout limit / cycle timer
//   CW_DEFAULT    : default width of the saturating event counter
//   timer_state_t : timer FSM state encoding (IDLE, RUN, EXPIRED)
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam int TW_DEFAULT = 8;
    localparam int CW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

endpackage : timer_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating event counter with a sticky overflow flag.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (count = 0, ovf = 0)
//   inc   : count one event this cycle
//   clr   : synchronous clear of count and ovf; wins over inc
//   count : registered event count, holds at all-ones
//   ovf   : registered sticky flag, set by an event arriving while saturated
// ---------------------------------------------------------------------------
module sat_counter
    import timer_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          ovf
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ovf_q;
    logic          ovf_d;

    // Next-state: clear beats increment; a saturated counter holds and flags
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = CNT_ZERO;
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            count_d = count_q;
            ovf_d   = ovf_q;
        end
    end

    // Counter and overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= CNT_ZERO;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule : sat_counter

// File: rtl/timeout_timer.sv
// ---------------------------------------------------------------------------
// timeout_timer
// Activity watchdog: a cycle timer that expires after `limit` quiet cycles,
// plus an independent saturating count of activity events.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset of all state and outputs
//   en_cont   : activity pulse; restarts the timeout window, counts an event
//   rst_timer : level; holds the timer in IDLE and releases an expiry
//   clr_count : synchronous clear of the event count and overflow flag
//   limit     : timeout length in cycles, 0 disables the timeout
//   to        : registered timeout flag, high only while EXPIRED
//   count     : registered saturating event count
//   ovf       : registered sticky overflow flag of the event counter
// ---------------------------------------------------------------------------
module timeout_timer
    import timer_pkg::*;
#(
    parameter int TW = TW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_cont,
    input  logic          rst_timer,
    input  logic          clr_count,
    input  logic [TW-1:0] limit,
    output logic          to,
    output logic [CW-1:0] count,
    output logic          ovf
);

    localparam logic [TW-1:0] T_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] T_ONE  = {{(TW-1){1'b0}}, 1'b1};

    timer_state_t  state_q;
    timer_state_t  state_d;
    logic [TW-1:0] t_q;
    logic [TW-1:0] t_d;
    logic          to_q;
    logic          to_d;
    logic [TW-1:0] t_inc_s;

    // Incremented timer wraps mod 2^TW, so a limit lowered below the current
    // count is only reached again after the wrap.
    assign t_inc_s = t_q + T_ONE;

    // Timer FSM next-state, timer value and timeout flag
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            IDLE: begin
                t_d = T_ZERO;
                if (rst_timer) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rst_timer) begin
                    state_d = IDLE;
                    t_d     = T_ZERO;
                end else if (en_cont) begin
                    // Activity wins even on the cycle that would have expired
                    t_d = T_ZERO;
                end else if (limit == T_ZERO) begin
                    t_d = t_q;
                end else if (t_inc_s == limit) begin
                    state_d = EXPIRED;
                    t_d     = t_inc_s;
                end else begin
                    t_d = t_inc_s;
                end
            end
            EXPIRED: begin
                if (rst_timer) begin
                    state_d = IDLE;
                    t_d     = T_ZERO;
                end else begin
                    state_d = EXPIRED;
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = T_ZERO;
            end
        endcase
        to_d = (state_d == EXPIRED);
    end

    // Timer state, cycle count and timeout flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= T_ZERO;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            to_q    <= to_d;
        end
    end

    assign to = to_q;

    sat_counter #(
        .CW (CW)
    ) u_sat_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (en_cont),
        .clr   (clr_count),
        .count (count),
        .ovf   (ovf)
    );

endmodule : timeout_timer

// File: tb/tb_timeout_timer.sv
// ---------------------------------------------------------------------------
// tb_timeout_timer
// Directed bench for timeout_timer (TW = 8, CW = 4) with hand-computed
// expectations. Inputs change 1 time unit after a rising edge; outputs are
// sampled at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_timeout_timer;

    localparam int TW = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          en_cont;
    logic          rst_timer;
    logic          clr_count;
    logic [TW-1:0] limit;
    logic          to;
    logic [CW-1:0] count;
    logic          ovf;

    int checks;
    int errors;

    timeout_timer #(
        .TW (TW),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_cont   (en_cont),
        .rst_timer (rst_timer),
        .clr_count (clr_count),
        .limit     (limit),
        .to        (to),
        .count     (count),
        .ovf       (ovf)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        en_cont   = 1'b0;
        rst_timer = 1'b1;
        clr_count = 1'b0;
        limit     = 8'd5;

        // Reset state
        tick();
        tick();
        check_eq("reset_to", {31'd0, to}, 32'd0);
        check_eq("reset_count", {28'd0, count}, 32'd0);
        check_eq("reset_ovf", {31'd0, ovf}, 32'd0);

        // Expiry latency with limit = 5: held in IDLE, then released
        rst = 1'b0;
        tick();
        check_eq("idle_hold_to", {31'd0, to}, 32'd0);
        rst_timer = 1'b0;
        tick();                                   // entered RUN, t = 0
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("lat5_before", {31'd0, to}, 32'd0);
        end
        tick();
        check_eq("lat5_rise", {31'd0, to}, 32'd1);

        // Stays expired for 20 cycles; one event is ignored by the timer
        for (int i = 0; i < 20; i++) begin
            en_cont = (i == 7);
            tick();
            check_eq("expired_hold", {31'd0, to}, 32'd1);
        end
        en_cont = 1'b0;
        check_eq("expired_evt_count", {28'd0, count}, 32'd1);

        // Release from EXPIRED with a one-cycle rst_timer; count unaffected
        rst_timer = 1'b1;
        tick();
        check_eq("release_to", {31'd0, to}, 32'd0);
        check_eq("release_count", {28'd0, count}, 32'd1);
        rst_timer = 1'b0;
        tick();                                   // IDLE -> RUN
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("rerun_before", {31'd0, to}, 32'd0);
        end
        tick();
        check_eq("rerun_rise", {31'd0, to}, 32'd1);
        check_eq("rerun_count", {28'd0, count}, 32'd1);

        // Periodic activity every 4 cycles keeps the timer alive
        rst_timer = 1'b1;
        clr_count = 1'b1;
        tick();
        check_eq("clr_count", {28'd0, count}, 32'd0);
        rst_timer = 1'b0;
        clr_count = 1'b0;
        tick();                                   // RUN, t = 0
        for (int i = 0; i < 40; i++) begin
            en_cont = ((i % 4) == 3);
            tick();
            check_eq("keepalive_to", {31'd0, to}, 32'd0);
        end
        en_cont = 1'b0;
        check_eq("keepalive_count", {28'd0, count}, 32'd10);

        // Activity on the would-expire cycle wins (t = 0 after last pulse)
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        en_cont = 1'b1;
        tick();
        en_cont = 1'b0;
        check_eq("tie_no_expiry", {31'd0, to}, 32'd0);
        check_eq("tie_count", {28'd0, count}, 32'd11);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check_eq("tie_before", {31'd0, to}, 32'd0);
        tick();
        check_eq("tie_rise", {31'd0, to}, 32'd1);

        // Limit lowered below t: expiry only after t wraps mod 256
        rst_timer = 1'b1;
        tick();
        rst_timer = 1'b0;
        tick();                                   // RUN, t = 0
        tick();
        tick();
        tick();                                   // t = 3
        limit = 8'd2;
        for (int i = 0; i < 254; i++) begin
            tick();
        end
        check_eq("wrap_before", {31'd0, to}, 32'd0);
        tick();
        check_eq("wrap_rise", {31'd0, to}, 32'd1);

        // Limit = 0 disables the timeout
        rst_timer = 1'b1;
        limit     = 8'd0;
        tick();
        rst_timer = 1'b0;
        tick();                                   // RUN, t held at 0
        for (int i = 0; i < 300; i++) begin
            tick();
            check_eq("limit0_to", {31'd0, to}, 32'd0);
        end
        limit = 8'd1;
        tick();
        check_eq("limit1_rise", {31'd0, to}, 32'd1);

        // Saturation and sticky overflow
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check_eq("sat_clr", {28'd0, count}, 32'd0);
        en_cont = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
        end
        check_eq("sat_15_count", {28'd0, count}, 32'd15);
        check_eq("sat_15_ovf", {31'd0, ovf}, 32'd0);
        tick();
        check_eq("sat_16_ovf", {31'd0, ovf}, 32'd1);
        tick();
        check_eq("sat_17_count", {28'd0, count}, 32'd15);
        check_eq("sat_17_ovf", {31'd0, ovf}, 32'd1);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check_eq("clr_wins_count", {28'd0, count}, 32'd0);
        check_eq("clr_wins_ovf", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        en_cont = 1'b0;
        check_eq("post_clr_count", {28'd0, count}, 32'd3);
        check_eq("post_clr_to", {31'd0, to}, 32'd1);
        en_cont = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
        end
        en_cont = 1'b0;
        check_eq("pre_rst_ovf", {31'd0, ovf}, 32'd1);

        // Asynchronous reset mid-cycle clears outputs before the next edge
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_to", {31'd0, to}, 32'd0);
        check_eq("async_count", {28'd0, count}, 32'd0);
        check_eq("async_ovf", {31'd0, ovf}, 32'd0);
        tick();
        rst = 1'b0;
        tick();                                   // IDLE -> RUN
        check_eq("post_rst_idle", {31'd0, to}, 32'd0);
        tick();
        check_eq("post_rst_rise", {31'd0, to}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_timeout_timer
